// File: rtl/regbank_wr_ctrl.sv
// regbank_wr_ctrl
//   Write-port controller for a 32 x 32 register bank. After reset it
//   optionally zero-fills r1..r31, then arbitrates between two write
//   requesters using a round-robin pointer. Register r0 is hard-wired
//   zero, so it is never written.
//
// Ports
//   clk             rising-edge clock shared with the register bank
//   rst             asynchronous active-high reset
//   req_a_valid     requester A (ALU writeback) has a write pending
//   req_a_reg       requester A destination register index
//   req_a_data      requester A write data
//   req_a_ready     requester A write accepted this cycle (combinational)
//   req_b_*         same as req_a_*, for requester B (load unit)
//   writereg        register bank write index (registered)
//   writedata       register bank write data (registered)
//   writeflag       register bank write enable (registered)
//   init_done       zero-fill finished, arbitration live
//
// Parameter
//   CLEAR_ON_RESET  1 = zero-fill after reset, 0 = go straight to arbitration
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | zero-fill: write 0 to r[cnt], cnt = 1..31; cnt wraps to 0
//         | after r31 is issued, which marks the hand-over cycle
// ST_RUN  | arbitration between requesters A and B, one write per cycle

module regbank_wr_ctrl #(
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a_valid,
   input  logic [4:0]  req_a_reg,
   input  logic [31:0] req_a_data,
   output logic        req_a_ready,
   input  logic        req_b_valid,
   input  logic [4:0]  req_b_reg,
   input  logic [31:0] req_b_data,
   output logic        req_b_ready,
   output logic [4:0]  writereg,
   output logic [31:0] writedata,
   output logic        writeflag,
   output logic        init_done
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
   localparam logic   PTR_A     = 1'b0;
   localparam logic   PTR_B     = 1'b1;

   state_t      state, state_nxt;
   logic [4:0]  cnt, cnt_nxt;
   logic        ptr, ptr_nxt;
   logic        flag_nxt;
   logic [4:0]  reg_nxt;
   logic [31:0] data_nxt;
   logic        done_nxt;
   logic        grant_a, grant_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RST_STATE;
         cnt       <= 5'd1;
         ptr       <= PTR_A;
         writeflag <= 1'b0;
         writereg  <= 5'd0;
         writedata <= 32'd0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ptr       <= ptr_nxt;
         writeflag <= flag_nxt;
         writereg  <= reg_nxt;
         writedata <= data_nxt;
         init_done <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      flag_nxt  = 1'b0;
      reg_nxt   = writereg;
      data_nxt  = writedata;
      done_nxt  = init_done;
      grant_a   = 1'b0;
      grant_b   = 1'b0;

      case (state)
         ST_INIT: begin
            // cnt == 0 only after the r31 write has been issued
            if (cnt == 5'd0) begin
               state_nxt = ST_RUN;
               done_nxt  = 1'b1;
            end else begin
               flag_nxt = 1'b1;
               reg_nxt  = cnt;
               data_nxt = 32'd0;
               cnt_nxt  = cnt + 5'd1;
            end
         end
         ST_RUN: begin
            done_nxt = 1'b1;
            if (req_a_valid && (!req_b_valid || ptr == PTR_A)) begin
               grant_a = 1'b1;
            end else if (req_b_valid) begin
               grant_b = 1'b1;
            end

            // A write to r0 is accepted and moves the pointer, but never
            // reaches the bank; the last index/data stay on the bus.
            if (grant_a) begin
               ptr_nxt = PTR_B;
               if (req_a_reg != 5'd0) begin
                  flag_nxt = 1'b1;
                  reg_nxt  = req_a_reg;
                  data_nxt = req_a_data;
               end
            end else if (grant_b) begin
               ptr_nxt = PTR_A;
               if (req_b_reg != 5'd0) begin
                  flag_nxt = 1'b1;
                  reg_nxt  = req_b_reg;
                  data_nxt = req_b_data;
               end
            end
         end
         default: state_nxt = RST_STATE;
      endcase

      // rst gates ready directly so nothing is acknowledged while reset is high
      req_a_ready = grant_a & ~rst;
      req_b_ready = grant_b & ~rst;
   end

endmodule

// File: tb/tb_regbank_wr_ctrl.sv
module tb_regbank_wr_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT with zero-fill
   logic        rst;
   logic        req_a_valid, req_b_valid;
   logic [4:0]  req_a_reg, req_b_reg;
   logic [31:0] req_a_data, req_b_data;
   logic        req_a_ready, req_b_ready;
   logic [4:0]  writereg;
   logic [31:0] writedata;
   logic        writeflag, init_done;

   // DUT without zero-fill
   logic        rst0;
   logic        a0_valid, b0_valid;
   logic [4:0]  a0_reg, b0_reg;
   logic [31:0] a0_data, b0_data;
   logic        a0_ready, b0_ready;
   logic [4:0]  w0_reg;
   logic [31:0] w0_data;
   logic        w0_flag, done0;

   regbank_wr_ctrl #(.CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst(rst),
      .req_a_valid(req_a_valid), .req_a_reg(req_a_reg), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
      .req_b_valid(req_b_valid), .req_b_reg(req_b_reg), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
      .writereg(writereg), .writedata(writedata), .writeflag(writeflag), .init_done(init_done)
   );

   regbank_wr_ctrl #(.CLEAR_ON_RESET(0)) dut0 (
      .clk(clk), .rst(rst0),
      .req_a_valid(a0_valid), .req_a_reg(a0_reg), .req_a_data(a0_data), .req_a_ready(a0_ready),
      .req_b_valid(b0_valid), .req_b_reg(b0_reg), .req_b_data(b0_data), .req_b_ready(b0_ready),
      .writereg(w0_reg), .writedata(w0_data), .writeflag(w0_flag), .init_done(done0)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [36:0] exp_q[$];
   logic [36:0] mon_e;
   logic [4:0]  last_reg;
   logic [31:0] last_data;
   logic        exp_done;
   logic        run_mode;
   logic        ptr_b;
   logic        pa_v, pb_v;
   logic [4:0]  pa_r, pb_r;
   logic [31:0] pa_d, pb_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every cycle the bank port either carries the next expected
   // write or holds its previous values
   initial begin
      forever begin
         @(negedge clk);
         chk("init_done", 64'(init_done), 64'(exp_done));
         if (writeflag === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 64'(writeflag), 64'(1'b0));
            end else begin
               mon_e = exp_q.pop_front();
               chk("write_reg", 64'(writereg), 64'(mon_e[36:32]));
               chk("write_data", 64'(writedata), 64'(mon_e[31:0]));
               last_reg  = mon_e[36:32];
               last_data = mon_e[31:0];
            end
         end else begin
            chk("hold_reg", 64'(writereg), 64'(last_reg));
            chk("hold_data", 64'(writedata), 64'(last_data));
         end
      end
   end

   task automatic new_requests();
      if (!pa_v && $urandom_range(0, 2) != 0) begin
         pa_v = 1'b1;
         pa_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         pa_d = $urandom;
      end
      if (!pb_v && $urandom_range(0, 2) != 0) begin
         pb_v = 1'b1;
         pb_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         pb_d = $urandom;
      end
   endtask

   // drive pending requests, check who the DUT accepts, record the write
   task automatic step();
      logic exp_a, exp_b;
      req_a_valid = pa_v; req_a_reg = pa_r; req_a_data = pa_d;
      req_b_valid = pb_v; req_b_reg = pb_r; req_b_data = pb_d;
      #1;
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (run_mode) begin
         if (pa_v && pb_v) begin
            if (ptr_b) exp_b = 1'b1;
            else       exp_a = 1'b1;
         end else if (pa_v) begin
            exp_a = 1'b1;
         end else if (pb_v) begin
            exp_b = 1'b1;
         end
      end
      chk("ready_a", 64'(req_a_ready), 64'(exp_a));
      chk("ready_b", 64'(req_b_ready), 64'(exp_b));
      if (exp_a) begin
         if (pa_r != 5'd0) exp_q.push_back({pa_r, pa_d});
         pa_v  = 1'b0;
         ptr_b = 1'b1;
      end
      if (exp_b) begin
         if (pb_r != 5'd0) exp_q.push_back({pb_r, pb_d});
         pb_v  = 1'b0;
         ptr_b = 1'b0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      step();
   endtask

   task automatic assert_rst();
      rst = 1'b1;
      exp_q.delete();
      last_reg  = 5'd0;
      last_data = 32'd0;
      exp_done  = 1'b0;
      run_mode  = 1'b0;
      ptr_b     = 1'b0;
      #1;
      chk("rst_writeflag", 64'(writeflag), 64'(1'b0));
      chk("rst_writereg", 64'(writereg), 64'(5'd0));
      chk("rst_writedata", 64'(writedata), 64'(32'd0));
      chk("rst_init_done", 64'(init_done), 64'(1'b0));
      chk("rst_ready_a", 64'(req_a_ready), 64'(1'b0));
      chk("rst_ready_b", 64'(req_b_ready), 64'(1'b0));
   endtask

   // release reset mid-cycle; the fill writes zero to r1..r31, then RUN
   task automatic release_and_fill(input int abort_after);
      for (int k = 1; k <= 31; k++) exp_q.push_back({5'(k), 32'h0});
      rst = 1'b0;
      step();
      for (int e = 1; e <= 31; e++) begin
         @(posedge clk);
         #1;
         if (e == abort_after) return;
         new_requests();
         step();
      end
      @(posedge clk);
      #1;
      exp_done = 1'b1;
      run_mode = 1'b1;
      step();
   endtask

   initial begin
      rst = 1'b0; rst0 = 1'b0;
      req_a_valid = 1'b0; req_a_reg = '0; req_a_data = '0;
      req_b_valid = 1'b0; req_b_reg = '0; req_b_data = '0;
      a0_valid = 1'b0; a0_reg = '0; a0_data = '0;
      b0_valid = 1'b0; b0_reg = '0; b0_data = '0;
      last_reg = '0; last_data = '0; exp_done = 1'b0; run_mode = 1'b0; ptr_b = 1'b0;
      pa_v = 1'b0; pa_r = '0; pa_d = '0;
      pb_v = 1'b0; pb_r = '0; pb_d = '0;
      #2;
      rst  = 1'b1;
      rst0 = 1'b1;

      // both requesters waiting through reset and the whole fill
      pa_v = 1'b1; pa_r = 5'd3; pa_d = 32'h1111_0003;
      pb_v = 1'b1; pb_r = 5'd4; pb_d = 32'h2222_0004;
      @(posedge clk); #1;
      assert_rst();
      @(posedge clk); #1;
      step();
      @(posedge clk); #2;
      release_and_fill(0);
      cycle();

      // A alone
      for (int i = 0; i < 4 && (pa_v || pb_v); i++) cycle();
      pa_v = 1'b1; pa_r = 5'd5; pa_d = 32'hDEAD_BEEF;
      cycle();
      chk("a_alone_ready", 64'(req_a_ready), 64'(1'b1));

      // B writes r0: accepted, no bank write, pointer moves to A
      pb_v = 1'b1; pb_r = 5'd0; pb_d = 32'h1234_5678;
      cycle();
      chk("b_r0_ready", 64'(req_b_ready), 64'(1'b1));

      // contention for four cycles: A, B, A, B
      for (int i = 0; i < 4; i++) begin
         if (!pa_v) begin pa_v = 1'b1; pa_r = 5'(10 + i); pa_d = 32'hA000_0000 + 32'(i); end
         if (!pb_v) begin pb_v = 1'b1; pb_r = 5'(20 + i); pb_d = 32'hB000_0000 + 32'(i); end
         cycle();
         chk("rr_order_a", 64'(req_a_ready), 64'((i % 2) == 0));
         chk("rr_order_b", 64'(req_b_ready), 64'((i % 2) == 1));
      end

      repeat (300) begin
         new_requests();
         @(posedge clk); #1;
         step();
      end

      // reset in RUN right after a handshake: that write is dropped
      if (!pa_v) begin pa_v = 1'b1; pa_r = 5'd7; pa_d = 32'h7777_7777; end
      cycle();
      #1;
      assert_rst();
      @(posedge clk); #1;
      step();
      @(posedge clk); #2;
      release_and_fill(0);
      repeat (40) begin
         new_requests();
         cycle();
      end

      // reset while cnt = 17, fill restarts at r1
      @(posedge clk); #2;
      assert_rst();
      @(posedge clk); #1;
      step();
      @(posedge clk); #2;
      release_and_fill(16);
      assert_rst();
      @(posedge clk); #1;
      step();
      @(posedge clk); #2;
      release_and_fill(0);
      repeat (40) begin
         new_requests();
         cycle();
      end

      // drain
      repeat (6) cycle();
      @(negedge clk);
      @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));

      // no zero-fill variant
      a0_valid = 1'b1; a0_reg = 5'd9; a0_data = 32'hCAFE_0009;
      @(posedge clk); #2;
      chk("nf_rst_ready", 64'(a0_ready), 64'(1'b0));
      chk("nf_rst_done", 64'(done0), 64'(1'b0));
      rst0 = 1'b0;
      #1;
      chk("nf_ready_a", 64'(a0_ready), 64'(1'b1));
      chk("nf_ready_b", 64'(b0_ready), 64'(1'b0));
      @(posedge clk); #1;
      a0_valid = 1'b0;
      chk("nf_done", 64'(done0), 64'(1'b1));
      chk("nf_flag", 64'(w0_flag), 64'(1'b1));
      chk("nf_reg", 64'(w0_reg), 64'(5'd9));
      chk("nf_data", 64'(w0_data), 64'(32'hCAFE_0009));
      repeat (4) begin
         @(posedge clk); #1;
         chk("nf_no_fill", 64'(w0_flag), 64'(1'b0));
         chk("nf_done_hold", 64'(done0), 64'(1'b1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regbank_wr_ctrl.md
REGBANK_WR_CTRL -- requirements
Module: regbank_wr_ctrl

Interface
REQ-001 SHALL have parameter: CLEAR_ON_RESET, default 1, 1 = run the zero-fill sequence after reset, 0 = skip it.
REQ-002 SHALL have one clock; reset is asynchronous and active-high: port clk, input, 1 bit, rising-edge clock shared with the register bank.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port req_a_valid, input, 1 bit, requester A (ALU writeback) has a write pending.
REQ-005 SHALL have port req_a_reg, input, 5 bits, destination register index of requester A.
REQ-006 SHALL have port req_a_data, input, 32 bits, write data of requester A.
REQ-007 SHALL have port req_a_ready, output, 1 bit, requester A's write is accepted this cycle.
REQ-008 SHALL have ports req_b_valid / req_b_reg / req_b_data / req_b_ready, same directions, widths and meanings as REQ-004..007, for requester B (load unit).
REQ-009 SHALL have port writereg, output, 5 bits, register bank write index.
REQ-010 SHALL have port writedata, output, 32 bits, register bank write data.
REQ-011 SHALL have port writeflag, output, 1 bit, register bank write enable.
REQ-012 SHALL have port init_done, output, 1 bit, high once the zero-fill is complete and arbitration is live.

Function
REQ-013 SHALL implement two states: INIT (zero-fill) and RUN (arbitration).
REQ-014 SHALL, in INIT, drive a registered write each cycle: writeflag=1, writereg=cnt, writedata=0, with cnt stepping 1,2,...,31 (r0 is never written).
REQ-015 SHALL leave INIT for RUN on the cycle after the write to index 31; init_done rises on the same edge and stays high until reset.
REQ-016 SHALL, when CLEAR_ON_RESET=0, enter RUN directly from reset, with init_done=1 on the first edge after rst deasserts.
REQ-017 SHALL hold req_a_ready=req_b_ready=0 throughout INIT and while rst is high.
REQ-018 SHALL, in RUN, compute ready combinationally: at most one of req_a_ready/req_b_ready is high in any cycle; a handshake is valid&ready.
REQ-019 SHALL, with only one valid request, grant it in the same cycle.
REQ-020 SHALL, with both valid, grant the requester indicated by a round-robin pointer; after any grant the pointer points to the non-granted requester.
REQ-021 SHALL present an accepted request on writereg/writedata with writeflag=1 on the next rising edge (latency 1, registered outputs), then writeflag=0 unless another handshake occurred.
REQ-022 SHALL accept (ready=1) a request with reg index 0 but SHALL hold writeflag=0 for it; it still counts as a grant for the pointer.
REQ-023 SHALL leave writereg/writedata at their last values when writeflag=0.
REQ-024 SHALL sustain one accepted write per cycle when requests are back-to-back.
REQ-025 SHALL keep a non-granted requester's ready low; the requester holds valid/reg/data stable until granted.

Reset
REQ-026 SHALL, on rst high, immediately force: state=INIT (or RUN if CLEAR_ON_RESET=0), cnt=1, pointer=A, writeflag=0, writereg=0, writedata=0, init_done=0, both readys 0.
REQ-027 SHALL restart the zero-fill from index 1 if rst asserts mid-INIT or mid-RUN; any write accepted in the cycle of reset assertion is dropped.

Verification
REQ-028 SHALL cover: reset release, CLEAR_ON_RESET=1 -> writeflag=1 for exactly 31 cycles, writereg 1..31, writedata 0; init_done=1 on the next edge; readys 0 throughout.
REQ-029 SHALL cover: RUN, A only valid, reg=5, data=0xDEADBEEF -> req_a_ready=1 same cycle; next edge writeflag=1, writereg=5, writedata=0xDEADBEEF.
REQ-030 SHALL cover: A and B both valid for 4 cycles, pointer=A -> grants A,B,A,B; writes appear on cycles 1..4 after the first grant in that order.
REQ-031 SHALL cover: B valid, reg=0, data=0x12345678 -> req_b_ready=1; next edge writeflag=0; a following A/B contention grants A.
REQ-032 SHALL cover: rst pulsed when cnt=17 -> outputs zero asynchronously; after release the fill restarts at writereg=1 and init_done stays 0 until 31 is written.
REQ-033 SHALL cover: CLEAR_ON_RESET=0, A valid on the first cycle after reset release -> init_done=1 and req_a_ready=1 with no fill writes.
